// File: rtl/vga_pkg.sv
// Shared timing defaults, RGB332 colour constants and board cell encoding for
// the VGA board renderer.
package vga_pkg;

  localparam int CLK_DIV_DEF   = 2;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_TOTAL_DEF   = 800;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_TOTAL_DEF   = 525;
  localparam int BOARD_X0_DEF  = 96;
  localparam int BOARD_Y0_DEF  = 48;

  localparam int CELL_SIZE = 64;
  localparam int CELL_COLS = 7;
  localparam int CELL_ROWS = 6;
  localparam int NUM_CELLS = CELL_COLS * CELL_ROWS;

  localparam logic [7:0] COLOR_BLANK  = 8'h00;
  localparam logic [7:0] COLOR_BG     = 8'h03;
  localparam logic [7:0] COLOR_EMPTY  = 8'hFF;
  localparam logic [7:0] COLOR_P1     = 8'hE0;
  localparam logic [7:0] COLOR_P2     = 8'hFC;
  localparam logic [7:0] COLOR_HILITE = 8'h1C;
  localparam logic [7:0] COLOR_GRID   = 8'h00;

  typedef enum logic [1:0] {
    CELL_EMPTY  = 2'd0,
    CELL_P1     = 2'd1,
    CELL_P2     = 2'd2,
    CELL_HILITE = 2'd3
  } cell_t;

  function automatic logic [7:0] cell_color(input cell_t c);
    case (c)
      CELL_P1:     return COLOR_P1;
      CELL_P2:     return COLOR_P2;
      CELL_HILITE: return COLOR_HILITE;
      default:     return COLOR_EMPTY;
    endcase
  endfunction

  // Row-major flat index; only meaningful for row < 6, col < 7.
  function automatic logic [5:0] cell_index(input logic [2:0] row, input logic [2:0] col);
    return ({3'b000, row} * 6'd7) + {3'b000, col};
  endfunction

endpackage

// File: rtl/vga_board_renderer_if.sv
// Board renderer bus: sync inputs, cell write port and pixel outputs.
interface vga_board_renderer_if;

  logic       h_sync;
  logic       v_sync;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [1:0] wr_val;
  logic       clear;
  logic [7:0] pixel_color;
  logic       frame_start;

  modport master (
    output h_sync, v_sync, wr_en, wr_row, wr_col, wr_val, clear,
    input  pixel_color, frame_start
  );

  modport slave (
    input  h_sync, v_sync, wr_en, wr_row, wr_col, wr_val, clear,
    output pixel_color, frame_start
  );

endinterface

// File: rtl/vga_board_mem.sv
// Working board (written by the game) and shadow board (read by the renderer),
// with clear and frame-boundary copy.
module vga_board_mem
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  logic [1:0] wr_val,
  input  logic       clear,
  input  logic       copy,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output cell_t      rd_cell
);

  cell_t work   [NUM_CELLS];
  cell_t shadow [NUM_CELLS];

  logic wr_ok;
  assign wr_ok = wr_en && (wr_row < 3'd6) && (wr_col < 3'd7);

  // Copy and write share an edge, so the shadow takes the pre-write contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        work[i]   <= CELL_EMPTY;
        shadow[i] <= CELL_EMPTY;
      end
    end else begin
      if (copy) begin
        for (int i = 0; i < NUM_CELLS; i++) shadow[i] <= work[i];
      end
      if (clear) begin
        for (int i = 0; i < NUM_CELLS; i++) work[i] <= CELL_EMPTY;
      end else if (wr_ok) begin
        work[cell_index(wr_row, wr_col)] <= cell_t'(wr_val);
      end
    end
  end

  always_comb begin
    rd_cell = CELL_EMPTY;
    if ((rd_row < 3'd6) && (rd_col < 3'd7)) rd_cell = shadow[cell_index(rd_row, rd_col)];
  end

endmodule

// File: rtl/vga_board_renderer.sv
// Pixel counters aligned to external syncs, 2-stage board pixel pipeline.
// Optional grid lines on cell borders when RENDER_GRID_EN is defined.
module vga_board_renderer
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_TOTAL   = H_TOTAL_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_TOTAL   = V_TOTAL_DEF,
  parameter int BOARD_X0  = BOARD_X0_DEF,
  parameter int BOARD_Y0  = BOARD_Y0_DEF
)(
  input logic                 clk,
  input logic                 reset,
  vga_board_renderer_if.slave bus
);

  localparam int BOARD_W = CELL_COLS * CELL_SIZE;
  localparam int BOARD_H = CELL_ROWS * CELL_SIZE;

  logic [7:0] div;
  logic [9:0] x, y;
  logic       hs_q, vs_q, frame_start_q;
  logic       tick, line_end, h_fall, v_fall;

  assign tick     = (div == 8'(CLK_DIV - 1));
  assign line_end = (x == 10'(H_TOTAL - 1));
  assign h_fall   = hs_q & ~bus.h_sync;
  assign v_fall   = vs_q & ~bus.v_sync;

  // Sync edges override the free-running count; the h edge also re-phases the divider.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div           <= '0;
      x             <= '0;
      y             <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hs_q          <= bus.h_sync;
      vs_q          <= bus.v_sync;
      frame_start_q <= v_fall;
      if (h_fall) begin
        x   <= 10'(H_VISIBLE + H_FP);
        div <= '0;
      end else begin
        div <= tick ? '0 : div + 8'd1;
        if (tick) x <= line_end ? '0 : x + 10'd1;
      end
      if (v_fall) y <= 10'(V_VISIBLE + V_FP);
      else if (tick && line_end && !h_fall) y <= (y == 10'(V_TOTAL - 1)) ? '0 : y + 10'd1;
    end
  end

  // Stage p1: region decode and cell coordinates.
  logic [9:0] dx, dy;
  logic       vld_p1, board_p1;
  logic [2:0] col_p1, row_p1;
  assign dx = x - 10'(BOARD_X0);
  assign dy = y - 10'(BOARD_Y0);

`ifdef RENDER_GRID_EN
  logic [5:0] lx_p1, ly_p1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      board_p1 <= 1'b0;
      col_p1   <= '0;
      row_p1   <= '0;
`ifdef RENDER_GRID_EN
      lx_p1    <= '0;
      ly_p1    <= '0;
`endif
    end else begin
      vld_p1   <= (x < 10'(H_VISIBLE)) && (y < 10'(V_VISIBLE));
      board_p1 <= (dx < 10'(BOARD_W)) && (dy < 10'(BOARD_H));
      col_p1   <= dx[8:6];
      row_p1   <= dy[8:6];
`ifdef RENDER_GRID_EN
      lx_p1    <= dx[5:0];
      ly_p1    <= dy[5:0];
`endif
    end
  end

  cell_t rd_cell;

  vga_board_mem u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_row  (bus.wr_row),
    .wr_col  (bus.wr_col),
    .wr_val  (bus.wr_val),
    .clear   (bus.clear),
    .copy    (v_fall),
    .rd_row  (row_p1),
    .rd_col  (col_p1),
    .rd_cell (rd_cell)
  );

  // Stage p2: colour select and output register.
  logic [7:0] color_d, color_p2;
  logic       grid;

`ifdef RENDER_GRID_EN
  assign grid = (lx_p1 == 6'd0) || (lx_p1 == 6'd63) || (ly_p1 == 6'd0) || (ly_p1 == 6'd63);
`else
  assign grid = 1'b0;
`endif

  always_comb begin
    color_d = COLOR_BLANK;
    if (vld_p1) begin
      if (!board_p1) color_d = COLOR_BG;
      else if (grid) color_d = COLOR_GRID;
      else           color_d = cell_color(rd_cell);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) color_p2 <= COLOR_BLANK;
    else        color_p2 <= color_d;
  end

  assign bus.pixel_color = color_p2;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed bench for vga_board_renderer: pixel tables per frame plus sync,
// wrap, reset and clear sequences. Lines are fast-forwarded with h_sync pulses.
module tb_vga_board_renderer;

  localparam int H_T = 700;
  localparam int V_T = 495;

`ifdef RENDER_GRID_EN
  localparam logic [7:0] GRID_C = 8'h00;
`else
  localparam logic [7:0] GRID_C = 8'hFF;
`endif

  typedef struct {
    int         px;
    int         py;
    logic [7:0] color;
  } pix_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_board_renderer_if bus();

  vga_board_renderer #(
    .CLK_DIV(2), .H_VISIBLE(640), .H_FP(16), .H_TOTAL(H_T),
    .V_VISIBLE(480), .V_FP(10), .V_TOTAL(V_T), .BOARD_X0(96), .BOARD_Y0(48)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  pix_t frame_a [9];
  pix_t frame_b [4];
  pix_t frame_c [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Walks the raster to (xt,yt), pulsing h_sync to skip the rest of non-target lines.
  task automatic seek(input int xt, input int yt, output bit hit);
    hit = 1'b0;
    for (int n = 0; n < 12000 && !hit; n++) begin
      if (int'(dut.x) == xt && int'(dut.y) == yt) hit = 1'b1;
      else begin
        if (int'(dut.y) != yt && dut.x < 10'd600) bus.h_sync = 1'b0;
        step();
        bus.h_sync = 1'b1;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL seek(%0d,%0d): timed out at x=%0d y=%0d", xt, yt, dut.x, dut.y);
    end
  endtask

  task automatic check_pixel(input string tag, input pix_t p);
    bit hit;
    seek(p.px, p.py, hit);
    if (hit) begin
      step();
      step();
      chk($sformatf("%s(%0d,%0d)", tag, p.px, p.py), bus.pixel_color, p.color);
    end
  endtask

  task automatic write_cell(input int r, input int c, input int v);
    bus.wr_en  = 1'b1;
    bus.wr_row = 3'(r);
    bus.wr_col = 3'(c);
    bus.wr_val = 2'(v);
    step();
    bus.wr_en  = 1'b0;
  endtask

  task automatic wrap_check(input int yfrom, input int yexp);
    bit hit;
    seek(H_T - 1, yfrom, hit);
    if (hit) begin
      for (int n = 0; n < 4 && int'(dut.x) == H_T - 1; n++) step();
      chk($sformatf("x_wrap_y%0d", yfrom), dut.x, 0);
      chk($sformatf("y_after_y%0d", yfrom), dut.y, yexp);
    end
  endtask

  initial begin
    frame_a[0] = '{10, 10, 8'h03};
    frame_a[1] = '{95, 48, 8'h03};
    frame_a[2] = '{96, 48, GRID_C};
    frame_a[3] = '{160, 48, GRID_C};
    frame_a[4] = '{543, 48, GRID_C};
    frame_a[5] = '{544, 48, 8'h03};
    frame_a[6] = '{640, 48, 8'h00};
    frame_a[7] = '{97, 49, 8'hFF};
    frame_a[8] = '{161, 49, 8'hFF};

    frame_b[0] = '{97, 49, 8'hE0};
    frame_b[1] = '{161, 49, 8'hFF};
    frame_b[2] = '{225, 49, 8'hFF};
    frame_b[3] = '{100, 60, 8'hE0};

    frame_c[0] = '{97, 49, 8'hFF};
    frame_c[1] = '{161, 49, 8'hFF};
    frame_c[2] = '{289, 49, 8'hFF};
    frame_c[3] = '{353, 49, 8'hFF};
    frame_c[4] = '{417, 49, 8'hFF};

    reset      = 1'b0;
    bus.h_sync = 1'b1;
    bus.v_sync = 1'b1;
    bus.clear  = 1'b0;
    bus.wr_en  = 1'b1;
    bus.wr_row = 3'd0;
    bus.wr_col = 3'd2;
    bus.wr_val = 2'd2;
    repeat (4) step();
    bus.wr_en = 1'b0;
    chk("rst_pixel", bus.pixel_color, 8'h00);
    chk("rst_frame_start", bus.frame_start, 1'b0);
    chk("rst_x", dut.x, 0);
    chk("rst_y", dut.y, 0);
    chk("rst_div", dut.div, 0);
    reset = 1'b1;

    // Mid-frame writes land in the working board only.
    write_cell(0, 0, 1);
    write_cell(6, 2, 2);
    write_cell(1, 7, 2);
    for (int i = 0; i < 9; i++) check_pixel("frameA", frame_a[i]);

    // Frame boundary with a same-cycle write that must miss the shadow copy.
    bus.wr_en  = 1'b1;
    bus.wr_row = 3'd0;
    bus.wr_col = 3'd1;
    bus.wr_val = 2'd2;
    bus.v_sync = 1'b0;
    step();
    bus.v_sync = 1'b1;
    bus.wr_en  = 1'b0;
    chk("frame_start_pulse", bus.frame_start, 1'b1);
    chk("vsync_y", dut.y, 490);
    step();
    chk("frame_start_single", bus.frame_start, 1'b0);
    step();
    chk("vblank_pixel", bus.pixel_color, 8'h00);

    // h_sync fall while the divider would otherwise advance.
    for (int n = 0; n < 4 && dut.div != 8'd0; n++) step();
    bus.h_sync = 1'b0;
    step();
    bus.h_sync = 1'b1;
    chk("hsync_x", dut.x, 656);
    chk("hsync_div", dut.div, 0);
    step();
    chk("hsync_x_hold", dut.x, 656);
    step();
    chk("hsync_x_tick", dut.x, 657);

    wrap_check(490, 491);
    wrap_check(V_T - 1, 0);

    for (int i = 0; i < 4; i++) check_pixel("frameB", frame_b[i]);

    write_cell(0, 5, 2);
    reset = 1'b0;
    step();
    chk("midrst_pixel", bus.pixel_color, 8'h00);
    chk("midrst_frame_start", bus.frame_start, 1'b0);
    chk("midrst_x", dut.x, 0);
    chk("midrst_y", dut.y, 0);
    reset = 1'b1;
    check_pixel("postrst", '{97, 49, 8'hFF});

    write_cell(0, 3, 1);
    bus.clear  = 1'b1;
    bus.wr_en  = 1'b1;
    bus.wr_row = 3'd0;
    bus.wr_col = 3'd4;
    bus.wr_val = 2'd2;
    step();
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    bus.v_sync = 1'b0;
    step();
    bus.v_sync = 1'b1;
    chk("frame_start_pulse2", bus.frame_start, 1'b1);
    for (int i = 0; i < 5; i++) check_pixel("frameC", frame_c[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_board_renderer.md
VGA_BOARD_RENDERER -- requirements
Module: vga_board_renderer

Interface
REQ-001 Single clock clk; reset is synchronous and active-low, named reset; all state SHALL update only on posedge clk.
REQ-002 Parameter CLK_DIV, 2, clk cycles per pixel.
REQ-003 Parameters H_VISIBLE/H_FP/H_TOTAL, 640/16/800; V_VISIBLE/V_FP/V_TOTAL, 480/10/525.
REQ-004 Parameters BOARD_X0/BOARD_Y0, 96/48, board top-left pixel; cell size fixed 64x64, 7 cols x 6 rows.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  synchronous active-low reset.
REQ-007 h_sync, v_sync  in  1 each  active-low syncs from vga_driver.
REQ-008 wr_en  in  1; wr_row  in  3; wr_col  in  3; wr_val  in  2  cell write port.
REQ-009 clear  in  1  clears all working cells to EMPTY.
REQ-010 pixel_color  out  8  RGB332 (R[7:5] G[4:2] B[1:0]) to vga_driver.
REQ-011 frame_start  out  1  one-cycle pulse when the shadow board is loaded.

Function
REQ-012 Pixel tick SHALL assert once every CLK_DIV clk cycles; x/y counters advance only on tick.
REQ-013 x SHALL wrap H_TOTAL-1 -> 0 and increment y; y SHALL wrap V_TOTAL-1 -> 0.
REQ-014 h_sync falling edge SHALL force x = H_VISIBLE+H_FP and restart the tick divider; v_sync falling edge SHALL force y = V_VISIBLE+V_FP.
REQ-015 Cell encoding: 0 EMPTY, 1 P1, 2 P2, 3 HILITE.
REQ-016 Colours: outside visible area 8'h00; background 8'h03; EMPTY 8'hFF; P1 8'hE0; P2 8'hFC; HILITE 8'h1C.
REQ-017 Pixel pipeline SHALL be 2 stages: stage 1 registers in_board, col = (x-BOARD_X0)>>6, row = (y-BOARD_Y0)>>6, local offsets; stage 2 registers pixel_color; latency 2 clk from counter update.
REQ-018 wr_en with row<6 and col<7 SHALL write wr_val into the working array next edge; out-of-range writes SHALL be ignored.
REQ-019 clear SHALL zero all 42 working cells; clear and wr_en in the same cycle: clear wins.
REQ-020 On v_sync falling edge the shadow array SHALL copy the working array (pre-write value for that cycle) and frame_start SHALL pulse for exactly one cycle.
REQ-021 Rendering SHALL read only the shadow array; a write never changes the frame in progress.

Reset
REQ-022 While reset=0: x, y, divider = 0; working and shadow cells = EMPTY; pipeline regs and pixel_color = 8'h00; frame_start = 0; sync edge-detect regs = 1.
REQ-023 Reset mid-frame SHALL take effect the next edge; writes during reset SHALL be dropped.

Configuration
REQ-024 Macro RENDER_GRID_EN defined: pixels with local x or y offset 0 or 63 inside the board SHALL be 8'h00 (grid lines); undefined: the entire cell area uses the cell colour; latency unchanged either way.

Structure
REQ-025 Package vga_pkg SHALL hold timing defaults, colour constants and typedef enum logic [1:0] cell_t.
REQ-026 Sub-module vga_board_mem SHALL contain the working/shadow arrays, write port, clear and copy; the top holds counters, sync alignment and pixel pipeline.

Verification
REQ-027 Reset held 4 cycles -> pixel_color=00, frame_start=0; after release, no write -> board cells render FF, background 03.
REQ-028 Write row 0 col 0 = P1 mid-frame -> current frame still FF at pixel (96,48); after next v_sync fall frame_start pulses once, pixel (96+1,48+1) = E0 two clk after counter reaches it.
REQ-029 wr_en row 6 col 2 and row 1 col 7 -> no cell changes; clear with wr_en same cycle -> all cells EMPTY next frame.
REQ-030 Drive h_sync fall with counter deliberately misaligned -> x = 656 next cycle, divider restarted; x wraps 799 -> 0 with y incremented, y wraps 524 -> 0.
REQ-031 RENDER_GRID_EN defined -> pixel (160,48) = 00 and (161,49) = FF; undefined -> both FF.
REQ-032 Assert reset mid-line -> next edge all outputs at reset values, cells EMPTY after release.
